// File: rtl/bootrom_line_fetcher.sv
// Refill adapter: splits one cache-line request into 64-bit boot ROM beats,
// reassembles the line and returns it over a valid/ready handshake.
module bootrom_line_fetcher #(
  parameter int ADDR_WIDTH     = 24,
  parameter int LINE_BYTES     = 16,
  parameter int ROM_BYTES      = 65536,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req_valid_i,
  output logic                    fetch_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   fetch_req_addr_i,
  input  logic                    fetch_kill_i,
  output logic                    fetch_resp_valid_o,
  input  logic                    fetch_resp_ready_i,
  output logic [LINE_BYTES*8-1:0] fetch_resp_data_o,
  output logic                    fetch_resp_error_o,
  output logic                    brom_req_valid_o,
  output logic [ADDR_WIDTH-1:0]   brom_req_address_o,
  input  logic                    brom_ready_i,
  input  logic [63:0]             brom_resp_data_i,
  input  logic                    brom_resp_valid_i
);

  localparam int BEATS    = LINE_BYTES / 8;
  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W   = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [7:0]            tmo_q, tmo_d;
  logic [LINE_W-1:0]     buf_q, buf_d;
  logic                  err_q, err_d;

  logic                  ready_s;
  logic                  issue_s;
  logic                  accept_s;
  logic                  tmo_hit_s;
  logic                  last_beat_s;
  logic                  out_of_range_s;
  logic [ADDR_WIDTH-1:0] req_base_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;

  assign req_base_s     = {fetch_req_addr_i[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign out_of_range_s = (64'(req_base_s) >= 64'(ROM_BYTES));
  assign issue_addr_s   = base_q + ADDR_WIDTH'({beat_q, 3'b000});
  assign accept_s       = ready_s & fetch_req_valid_i;
  assign tmo_hit_s      = (tmo_q == 8'(TIMEOUT_CYCLES - 1));
  assign last_beat_s    = (beat_q == BEAT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a killed line never reaches RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = out_of_range_s ? RESP : ISSUE;
        else          state_d = IDLE;
      end
      ISSUE: begin
        if (brom_ready_i)      state_d = fetch_kill_i ? DRAIN : WAIT;
        else if (fetch_kill_i) state_d = IDLE;
        else                   state_d = ISSUE;
      end
      WAIT: begin
        if (brom_resp_valid_i) state_d = fetch_kill_i ? IDLE : (last_beat_s ? RESP : ISSUE);
        else if (tmo_hit_s)    state_d = fetch_kill_i ? IDLE : RESP;
        else if (fetch_kill_i) state_d = DRAIN;
        else                   state_d = WAIT;
      end
      DRAIN: begin
        if (brom_resp_valid_i || tmo_hit_s) state_d = IDLE;
        else                                state_d = DRAIN;
      end
      RESP: begin
        if (fetch_kill_i || fetch_resp_ready_i) state_d = IDLE;
        else                                    state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; ready depends only on state and kill, never on request valid
  always_comb begin
    ready_s = 1'b0;
    issue_s = 1'b0;
    case (state_q)
      IDLE:    ready_s = armed_q & ~fetch_kill_i;
      ISSUE:   issue_s = brom_ready_i;
      default: begin
        ready_s = 1'b0;
        issue_s = 1'b0;
      end
    endcase
    fetch_req_ready_o  = ready_s;
    brom_req_valid_o   = issue_s;
    brom_req_address_o = issue_s ? issue_addr_s : addr_q;
    fetch_resp_valid_o = (state_q == RESP);
    fetch_resp_data_o  = buf_q;
    fetch_resp_error_o = err_q;
  end

  // Datapath next values: line base, beat index, per-beat timeout, line buffer
  always_comb begin
    armed_d = 1'b1;
    base_d  = base_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    err_d   = err_q;
    if (accept_s) begin
      base_d = req_base_s;
      beat_d = {BEAT_W{1'b0}};
      buf_d  = {LINE_W{1'b0}};
      err_d  = out_of_range_s;
    end else if (issue_s) begin
      addr_d = issue_addr_s;
      tmo_d  = 8'd0;
    end else if ((state_q == WAIT) || (state_q == DRAIN)) begin
      if (brom_resp_valid_i) begin
        tmo_d = 8'd0;
        if ((state_q == WAIT) && !fetch_kill_i) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) buf_d[64*k +: 64] = brom_resp_data_i;
            else                      buf_d[64*k +: 64] = buf_q[64*k +: 64];
          end
          beat_d = last_beat_s ? beat_q : beat_q + BEAT_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end else if (tmo_hit_s) begin
        tmo_d = 8'd0;
        if ((state_q == WAIT) && !fetch_kill_i) begin
          buf_d = {LINE_W{1'b0}};
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      base_q  <= {ADDR_WIDTH{1'b0}};
      addr_q  <= {ADDR_WIDTH{1'b0}};
      beat_q  <= {BEAT_W{1'b0}};
      tmo_q   <= 8'd0;
      buf_q   <= {LINE_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bootrom_line_fetcher.sv
// Scoreboard bench for bootrom_line_fetcher with a behavioural 5-cycle boot ROM
// and a line-level reference model.
`timescale 1ns/1ps
module tb_bootrom_line_fetcher;

  localparam int AW    = 24;
  localparam int LB    = 16;
  localparam int RB    = 65536;
  localparam int TO    = 64;
  localparam int BEATS = LB / 8;
  localparam int LW    = LB * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req_valid_i = 1'b0;
  logic          fetch_req_ready_o;
  logic [AW-1:0] fetch_req_addr_i = '0;
  logic          fetch_kill_i = 1'b0;
  logic          fetch_resp_valid_o;
  logic          fetch_resp_ready_i = 1'b1;
  logic [LW-1:0] fetch_resp_data_o;
  logic          fetch_resp_error_o;
  logic          brom_req_valid_o;
  logic [AW-1:0] brom_req_address_o;
  logic          brom_ready_i = 1'b1;
  logic [63:0]   brom_resp_data_i = '0;
  logic          brom_resp_valid_i = 1'b0;

  always #5 clk = ~clk;

  bootrom_line_fetcher #(
    .ADDR_WIDTH(AW), .LINE_BYTES(LB), .ROM_BYTES(RB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid_i(fetch_req_valid_i), .fetch_req_ready_o(fetch_req_ready_o),
    .fetch_req_addr_i(fetch_req_addr_i), .fetch_kill_i(fetch_kill_i),
    .fetch_resp_valid_o(fetch_resp_valid_o), .fetch_resp_ready_i(fetch_resp_ready_i),
    .fetch_resp_data_o(fetch_resp_data_o), .fetch_resp_error_o(fetch_resp_error_o),
    .brom_req_valid_o(brom_req_valid_o), .brom_req_address_o(brom_req_address_o),
    .brom_ready_i(brom_ready_i), .brom_resp_data_i(brom_resp_data_i),
    .brom_resp_valid_i(brom_resp_valid_i)
  );

  logic [63:0]   mem [RB/8];
  logic [LW:0]   sb [$];
  logic [AW-1:0] exp_addr [$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            pulse_cnt = 0;
  int            last_issue_cyc = 0;
  bit            prev_req = 1'b0;
  bit            rom_silent = 1'b0;
  bit            stray_pulse = 1'b0;
  bit            pending = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] rom_addr = '0;
  int            cd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference: line = concatenation of ROM words, or an all-zero error line
  function automatic logic [LW:0] model(input logic [AW-1:0] a);
    logic [LW:0] r = '0;
    int unsigned base = (int'(a) / LB) * LB;
    if (base >= RB || rom_silent) r[LW] = 1'b1;
    else for (int k = 0; k < BEATS; k++) r[64*k +: 64] = mem[base/8 + k];
    return r;
  endfunction

  // ROM request monitor: one outstanding request, expected beat addresses
  initial forever begin
    @(negedge clk);
    if (brom_req_valid_o) begin
      check("brom_back_to_back", {159'd0, prev_req}, 160'd0);
      if (exp_addr.size() == 0) fail("brom_unexpected_issue", "got a ROM request, required none");
      else check("brom_addr", brom_req_address_o, exp_addr.pop_front());
      pending = 1'b1;
      pend_addr = brom_req_address_o;
      pulse_cnt++;
      last_issue_cyc = cyc;
    end
    prev_req = brom_req_valid_o;
  end

  // Behavioural boot ROM: valid 5 cycles after the issue cycle
  initial forever begin
    @(posedge clk); #1;
    brom_resp_valid_i = 1'b0;
    if (stray_pulse) begin
      brom_resp_valid_i = 1'b1;
      brom_resp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      stray_pulse = 1'b0;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        brom_resp_valid_i = 1'b1;
        brom_resp_data_i  = mem[(int'(rom_addr) / 8) % (RB/8)];
      end
    end
    if (pending) begin
      pending = 1'b0;
      if (!rom_silent) begin
        cd = 4;
        rom_addr = pend_addr;
      end
    end
    brom_ready_i = (cd == 0);
  end

  // Response monitor: pops the scoreboard on every line handshake
  initial forever begin
    @(negedge clk);
    if (fetch_resp_valid_o && fetch_resp_ready_i) begin
      if (sb.size() == 0) fail("resp_unexpected", "got a line response, required none");
      else check("resp_line", {fetch_resp_error_o, fetch_resp_data_o}, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input bit track, output int acc);
    int n = 0;
    int unsigned base = (int'(a) / LB) * LB;
    acc = 0;
    tick();
    fetch_req_valid_i = 1'b1;
    fetch_req_addr_i  = a;
    @(negedge clk);
    while (!fetch_req_ready_o && n < 300) begin @(negedge clk); n++; end
    if (!fetch_req_ready_o) fail("req_accept", "request never accepted");
    else begin
      acc = cyc;
      if (base < RB) for (int k = 0; k < BEATS; k++) exp_addr.push_back(AW'(base + 8*k));
      if (track) sb.push_back(model(a));
    end
    tick();
    fetch_req_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int vc);
    int n = 0;
    vc = -1;
    @(negedge clk);
    while (!fetch_resp_valid_o && n < maxc) begin @(negedge clk); n++; end
    if (fetch_resp_valid_o) vc = cyc;
    else fail("resp_wait", "no line response within cycle budget");
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin tick(); n++; end
    if (sb.size() != 0) fail("drain", "expected response still outstanding");
    tick();
  endtask

  task automatic check_zero(input string name);
    check(name, {fetch_req_ready_o, fetch_resp_valid_o, fetch_resp_error_o,
                 fetch_resp_data_o, brom_req_valid_o, brom_req_address_o}, 160'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, vc, p0, n;
    bit saw;
    for (int i = 0; i < RB/8; i++) mem[i] = {$urandom(), $urandom()};
    mem[0] = {16{4'h2}};
    mem[1] = {16{4'h1}};
    mem[2] = {16{4'h4}};
    mem[3] = {16{4'h3}};

    #1 rst = 1'b1;
    #2 check_zero("reset_outputs");
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // 1: line0 with latency
    p0 = pulse_cnt;
    send(24'h000004, 1'b1, a_cyc);
    wait_valid(40, vc);
    check("t1_latency", vc - a_cyc, 13);
    check("t1_resp_data", {fetch_resp_error_o, fetch_resp_data_o}, {1'b0, {16{4'h1}}, {16{4'h2}}});
    drain(50);
    check("t1_pulses", pulse_cnt - p0, 2);

    // 2: backpressure holds line1, blocks new requests
    fetch_resp_ready_i = 1'b0;
    send(24'h000018, 1'b1, a_cyc);
    wait_valid(40, vc);
    tick();
    fetch_req_valid_i = 1'b1;
    fetch_req_addr_i  = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold", {fetch_resp_valid_o, fetch_req_ready_o, fetch_resp_error_o, fetch_resp_data_o},
            {1'b1, 1'b0, 1'b0, {16{4'h3}}, {16{4'h4}}});
    end
    tick();
    fetch_req_valid_i = 1'b0;
    fetch_resp_ready_i = 1'b1;
    drain(20);

    // 3: out of range, no ROM access
    p0 = pulse_cnt;
    send(24'h010000, 1'b1, a_cyc);
    wait_valid(10, vc);
    check("t3_latency", vc - a_cyc, 1);
    drain(20);
    check("t3_no_pulse", pulse_cnt - p0, 0);

    // 4: silent ROM times out, stray beat ignored
    @(negedge clk); rom_silent = 1'b1;
    send(24'h000020, 1'b1, a_cyc);
    wait_valid(200, vc);
    check("t4_timeout_window", ((vc - last_issue_cyc) == TO) || ((vc - last_issue_cyc) == TO + 1), 1);
    drain(20);
    exp_addr.delete();
    @(negedge clk); rom_silent = 1'b0; stray_pulse = 1'b1;
    repeat (5) tick();
    send(24'h000028, 1'b1, a_cyc);
    drain(60);

    // 5: kill two cycles after beat 0 issue
    p0 = pulse_cnt;
    send(24'h000000, 1'b0, a_cyc);
    n = 0;
    @(negedge clk);
    while (!brom_req_valid_o && n < 50) begin @(negedge clk); n++; end
    tick(); tick();
    fetch_kill_i = 1'b1;
    tick();
    fetch_kill_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (fetch_resp_valid_o) saw = 1'b1; end
    check("t5_no_resp", saw, 1'b0);
    check("t5_pulses", pulse_cnt - p0, 1);
    check("t5_beat1_unissued", exp_addr.size(), 1);
    exp_addr.delete();
    send(24'h000000, 1'b1, a_cyc);
    drain(60);

    // 6: async reset during beat 1 wait
    send(24'h000010, 1'b1, a_cyc);
    n = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      while (!brom_req_valid_o && n < 100) begin @(negedge clk); n++; end
    end
    tick(); tick();
    #2 rst = 1'b1;
    #1 check_zero("t6_reset_outputs");
    sb.delete();
    exp_addr.delete();
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    send(24'h000030, 1'b1, a_cyc);
    drain(60);

    // Random lines with random backpressure
    for (int it = 0; it < 25; it++) begin
      send(AW'($urandom_range(0, 32'h0001_1000)), 1'b1, a_cyc);
      n = 0;
      while (sb.size() != 0 && n < 400) begin
        tick();
        fetch_resp_ready_i = 1'($urandom_range(0, 1));
        n++;
      end
      if (sb.size() != 0) fail("rand_drain", "random line response missing");
      tick();
      fetch_resp_ready_i = 1'b1;
      tick();
    end

    check("final_idle_ready", fetch_req_ready_o, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bootrom_line_fetcher.md
Name: bootrom_line_fetcher

Overview:
Upstream adapter between the instruction-fetch refill path and the behavioural boot ROM. It accepts one cache-line refill request and splits it into single-beat 64-bit boot ROM requests. It collects the returned beats into one line and hands the line back through a valid/ready handshake. It also handles out-of-range errors, response timeouts and fetch kill (flush) with drain.

Parameters:
ADDR_WIDTH, 24, byte address width (matches boot ROM request address).
LINE_BYTES, 16, refill line size in bytes; legal values 8, 16, 32; BEATS = LINE_BYTES/8.
ROM_BYTES, 65536, decoded ROM size; line base >= ROM_BYTES is out of range.
TIMEOUT_CYCLES, 64, maximum wait per beat from issue to response; legal range 8..255.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
fetch_req_valid_i  in  1  refill request valid.
fetch_req_ready_o  out  1  refill request accepted when valid&ready.
fetch_req_addr_i  in  ADDR_WIDTH  refill byte address; low log2(LINE_BYTES) bits ignored.
fetch_kill_i  in  1  flush; abandon the current line.
fetch_resp_valid_o  out  1  line response valid.
fetch_resp_ready_i  in  1  consumer accepts the response.
fetch_resp_data_o  out  LINE_BYTES*8  line data; beat k occupies bits [64k+63:64k].
fetch_resp_error_o  out  1  response is an error (out of range or timeout); data is all zeros.
brom_req_valid_o  out  1  boot ROM request, single-cycle pulse.
brom_req_address_o  out  ADDR_WIDTH  beat address.
brom_ready_i  in  1  boot ROM idle.
brom_resp_data_i  in  64  beat data.
brom_resp_valid_i  in  1  beat data valid (one-cycle pulse).

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: fetch_req_ready_o, fetch_resp_valid_o, fetch_resp_error_o, fetch_resp_data_o, brom_req_valid_o, brom_req_address_o. Beat counter, timeout counter and data buffer are cleared. Reset mid-transaction drops the line; no response is produced.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - fetch_req_ready_o = ~fetch_kill_i. Ready is registered-state based, with no combinational path from fetch_req_valid_i.
  - On a handshake, latch base = addr with the low bits cleared, and set beat=0.
  - If base >= ROM_BYTES: go to RESP with error=1 and data=0. No ROM access is made.
  - Otherwise go to ISSUE.
- ISSUE:
  - Wait for brom_ready_i=1. Then drive brom_req_valid_o=1 for exactly one cycle with brom_req_address_o = base + 8*beat, and go to WAIT.
  - brom_req_address_o holds its value until the next issue.
  - brom_resp_valid_i seen in the ISSUE cycle is stale and is ignored.
- WAIT:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - On brom_resp_valid_i: store the data into slot beat and clear the timeout counter.
    - If beat == BEATS-1, go to RESP with error=0.
    - Otherwise beat++ and go to ISSUE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response: go to RESP with error=1 and the data buffer zeroed.
- RESP:
  - fetch_resp_valid_o=1. Data and error are held stable until fetch_resp_ready_i. Then go to IDLE.
  - fetch_kill_i in RESP drops the response: go to IDLE next cycle, with valid deasserting that cycle.
- Kill:
  - In IDLE: ignored, apart from blocking acceptance.
  - In ISSUE before the pulse: go to IDLE directly, with no issue.
  - In the pulse cycle or in WAIT: go to DRAIN.
- DRAIN:
  - Wait for brom_resp_valid_i or timeout, discard the beat, then go to IDLE.
  - No fetch_resp_valid_o is produced for a killed line. Kill during DRAIN has no further effect.
- Simultaneous kill and brom_resp_valid_i in WAIT: the beat is consumed and discarded, and the next state is IDLE.
- Late beat: a ROM response arriving after a timeout, in RESP or IDLE, is ignored. No second request is issued to the ROM until brom_ready_i=1.
- Only one ROM request is outstanding at any time. brom_req_valid_o is never high on two consecutive cycles.
- Latency: use the zero-wait behavioural ROM, which raises valid 5 cycles after the issue cycle, and handshake in cycle A. Then with LINE_BYTES=16:
  - Beat 0 is issued at A+1 and returns at A+6.
  - Beat 1 is issued at A+7 and returns at A+12.
  - fetch_resp_valid_o=1 from A+13.

Test Plan:
1. ROM preloaded: line0 = 128'h1111..11_2222..22 (upper half 1s, lower half 2s), line1 = 128'h3333..33_4444..44. Request addr 0x000004 -> ROM addresses 0x0 then 0x8. Response data = {64'h1111..11, 64'h2222..22}, error=0, valid rises at A+13.
2. Request 0x000018 with fetch_resp_ready_i held low 10 cycles -> data {64'h3333..33, 64'h4444..44} held stable; a second request is not accepted (ready=0) until the response handshake.
3. Request 0x010000 (ROM_BYTES=65536) -> no brom_req_valid_o pulse, error response at A+1 with data=0.
4. Stub ROM that never responds -> after beat 0 issue, error response TIMEOUT_CYCLES cycles later. A later stray brom_resp_valid_i pulse is ignored, and the next request returns correct data.
5. Kill asserted 2 cycles after beat 0 issue -> FSM drains the beat, no fetch_resp_valid_o, beat 1 never issued. The next request 0x000000 returns line0 correctly.
6. Async rst pulse in WAIT of beat 1 -> all outputs 0 immediately, no response. Recovery request returns correct data.
